quad_pos_tracker: RTL and testbench

Two-axis quadrature position tracker that produces the `x_pos`, `y_pos` and `status` bytes consumed by the I2C read-only slave. It decodes two asynchronous quadrature encoder channel pairs into 8-bit position counters and accumulates sticky event flags. On a `snap` pulse it freezes all three output bytes together, so that one I2C read transaction always returns a coherent triple.

---
 rtl/pos_pkg.sv | 51 +++++
 rtl/quad_pos_tracker_if.sv | 27 ++
 rtl/quad_axis.sv | 77 +++++++
 rtl/quad_pos_tracker.sv | 111 +++++++++++
 tb/tb_quad_pos_tracker.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pos_pkg.sv
// Shared types and constants for the two-axis quadrature position tracker.
// Status bit positions, the default centre value and the Gray-code step decoder.
package pos_pkg;

    localparam int ST_MOV_X   = 0;
    localparam int ST_MOV_Y   = 1;
    localparam int ST_ERR_X   = 2;
    localparam int ST_ERR_Y   = 3;
    localparam int ST_OVF_X   = 4;
    localparam int ST_OVF_Y   = 5;
    localparam int ST_SEQ_LSB = 6;

    localparam int NUM_FLAGS = 6;

    localparam logic [7:0] POS_CENTER_DEFAULT = 8'd128;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2,
        STEP_ERR  = 2'd3
    } quad_step_t;

    // Forward direction walks 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] quad_next_phase(input logic [1:0] phase);
        logic [1:0] nxt;
        case (phase)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic quad_step_t quad_decode(input logic [1:0] prev,
                                               input logic [1:0] curr);
        quad_step_t s;
        if (prev == curr) begin
            s = STEP_NONE;
        end else if ((prev ^ curr) == 2'b11) begin
            s = STEP_ERR;
        end else if (quad_next_phase(prev) == curr) begin
            s = STEP_INC;
        end else begin
            s = STEP_DEC;
        end
        return s;
    endfunction

endpackage

// File: rtl/quad_pos_tracker_if.sv
// Encoder pins, snapshot/zero strobes and position/status bytes of the tracker.
// The master side drives encoders and strobes; the slave side is the tracker.
interface quad_pos_tracker_if;

    logic       x_a;
    logic       x_b;
    logic       y_a;
    logic       y_b;
    logic       snap;
    logic       zero;
    logic [7:0] x_pos;
    logic [7:0] y_pos;
    logic [7:0] status;
    logic [7:0] cnt_x;
    logic [7:0] cnt_y;

    modport master (
        output x_a, x_b, y_a, y_b, snap, zero,
        input  x_pos, y_pos, status, cnt_x, cnt_y
    );

    modport slave (
        input  x_a, x_b, y_a, y_b, snap, zero,
        output x_pos, y_pos, status, cnt_x, cnt_y
    );

endinterface

// File: rtl/quad_axis.sv
// One encoder axis: 2-FF synchronizer, previous-phase register, Gray-code step
// decode and an 8-bit position counter that either wraps or clamps.
module quad_axis
    import pos_pkg::*;
#(
    parameter logic [7:0] CENTER   = POS_CENTER_DEFAULT,
    parameter bit         SATURATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       zero_i,
    output logic [7:0] cnt_o,
    output quad_step_t step_o,
    output logic       ovf_o
);

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    quad_step_t step;
    logic       ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
            cnt_q   <= CENTER;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    // A zero strobe wins over a coincident step, so no overflow can be raised.
    always_comb begin
        step  = quad_decode(prev_q, sync2_q);
        cnt_d = cnt_q;
        ovf   = 1'b0;
        if (zero_i) begin
            cnt_d = CENTER;
        end else begin
            case (step)
                STEP_INC: begin
                    if (cnt_q == 8'hFF) begin
                        ovf   = 1'b1;
                        cnt_d = SATURATE ? cnt_q : 8'h00;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                STEP_DEC: begin
                    if (cnt_q == 8'h00) begin
                        ovf   = 1'b1;
                        cnt_d = SATURATE ? cnt_q : 8'hFF;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    assign cnt_o  = cnt_q;
    assign step_o = step;
    assign ovf_o  = ovf;

endmodule

// File: rtl/quad_pos_tracker.sv
// Two-axis quadrature position tracker with sticky event flags and a coherent
// snapshot of {x_pos, y_pos, status} taken on each snap strobe.
module quad_pos_tracker
    import pos_pkg::*;
#(
    parameter logic [7:0] CENTER   = POS_CENTER_DEFAULT,
    parameter bit         SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    quad_pos_tracker_if.slave   bus
);

    logic [7:0]           cnt_x;
    logic [7:0]           cnt_y;
    quad_step_t           step_x;
    quad_step_t           step_y;
    logic                 ovf_x;
    logic                 ovf_y;

    logic [NUM_FLAGS-1:0] ev;
    logic [NUM_FLAGS-1:0] flags_q;
    logic [NUM_FLAGS-1:0] flags_d;
    logic [1:0]           seq_q;
    logic [1:0]           seq_d;
    logic [7:0]           x_pos_q;
    logic [7:0]           x_pos_d;
    logic [7:0]           y_pos_q;
    logic [7:0]           y_pos_d;
    logic [7:0]           status_q;
    logic [7:0]           status_d;

    quad_axis #(
        .CENTER   (CENTER),
        .SATURATE (SATURATE)
    ) u_axis_x (
        .clk    (clk),
        .rst    (rst),
        .a_i    (bus.x_a),
        .b_i    (bus.x_b),
        .zero_i (bus.zero),
        .cnt_o  (cnt_x),
        .step_o (step_x),
        .ovf_o  (ovf_x)
    );

    quad_axis #(
        .CENTER   (CENTER),
        .SATURATE (SATURATE)
    ) u_axis_y (
        .clk    (clk),
        .rst    (rst),
        .a_i    (bus.y_a),
        .b_i    (bus.y_b),
        .zero_i (bus.zero),
        .cnt_o  (cnt_y),
        .step_o (step_y),
        .ovf_o  (ovf_y)
    );

    always_comb begin
        ev           = '0;
        ev[ST_MOV_X] = (step_x == STEP_INC) || (step_x == STEP_DEC);
        ev[ST_MOV_Y] = (step_y == STEP_INC) || (step_y == STEP_DEC);
        ev[ST_ERR_X] = (step_x == STEP_ERR);
        ev[ST_ERR_Y] = (step_y == STEP_ERR);
        ev[ST_OVF_X] = ovf_x;
        ev[ST_OVF_Y] = ovf_y;
    end

    // Snapshot takes the registered counts and flags; events of the snap cycle
    // open the new epoch instead of being folded into the byte being frozen.
    always_comb begin
        flags_d  = flags_q | ev;
        seq_d    = seq_q;
        x_pos_d  = x_pos_q;
        y_pos_d  = y_pos_q;
        status_d = status_q;
        if (bus.snap) begin
            flags_d                        = ev;
            seq_d                          = seq_q + 2'd1;
            x_pos_d                        = cnt_x;
            y_pos_d                        = cnt_y;
            status_d[ST_SEQ_LSB +: 2]      = seq_q + 2'd1;
            status_d[NUM_FLAGS-1:ST_MOV_X] = flags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= '0;
            seq_q    <= 2'd0;
            x_pos_q  <= CENTER;
            y_pos_q  <= CENTER;
            status_q <= 8'h00;
        end else begin
            flags_q  <= flags_d;
            seq_q    <= seq_d;
            x_pos_q  <= x_pos_d;
            y_pos_q  <= y_pos_d;
            status_q <= status_d;
        end
    end

    assign bus.x_pos  = x_pos_q;
    assign bus.y_pos  = y_pos_q;
    assign bus.status = status_q;
    assign bus.cnt_x  = cnt_x;
    assign bus.cnt_y  = cnt_y;

endmodule

// File: tb/tb_quad_pos_tracker.sv
// Directed bench for quad_pos_tracker: a wrapping and a saturating instance
// share the same encoder/strobe stimulus and are checked against hand values.
module tb_quad_pos_tracker;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] xph;
    logic [1:0] yph;

    quad_pos_tracker_if if0 ();
    quad_pos_tracker_if if1 ();

    assign if1.x_a  = if0.x_a;
    assign if1.x_b  = if0.x_b;
    assign if1.y_a  = if0.y_a;
    assign if1.y_b  = if0.y_b;
    assign if1.snap = if0.snap;
    assign if1.zero = if0.zero;

    quad_pos_tracker #(.CENTER(8'd128), .SATURATE(1'b0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    quad_pos_tracker #(.CENTER(8'd128), .SATURATE(1'b1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] bwd(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Drive a phase and wait long enough for it to reach the counter.
    task automatic drive_x(input logic [1:0] p);
        @(negedge clk);
        xph = p;
        if0.x_a = p[1];
        if0.x_b = p[0];
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_y(input logic [1:0] p);
        @(negedge clk);
        yph = p;
        if0.y_a = p[1];
        if0.y_b = p[0];
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_snap();
        @(negedge clk);
        if0.snap = 1'b1;
        @(negedge clk);
        if0.snap = 1'b0;
    endtask

    task automatic pulse_zero();
        @(negedge clk);
        if0.zero = 1'b1;
        @(negedge clk);
        if0.zero = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        xph = 2'b00;
        yph = 2'b00;
        if0.x_a = 1'b0; if0.x_b = 1'b0;
        if0.y_a = 1'b0; if0.y_b = 1'b0;
        if0.snap = 1'b0; if0.zero = 1'b0;
        repeat (3) @(negedge clk);

        check8("rst cnt_x",  if0.cnt_x,  8'd128);
        check8("rst cnt_y",  if0.cnt_y,  8'd128);
        check8("rst x_pos",  if0.x_pos,  8'd128);
        check8("rst y_pos",  if0.y_pos,  8'd128);
        check8("rst status", if0.status, 8'h00);
        check8("rst status sat", if1.status, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Five forward X steps, then two snapshots.
        for (int i = 0; i < 5; i++) drive_x(fwd(xph));
        check8("fwd cnt_x",     if0.cnt_x, 8'd133);
        check8("fwd cnt_x sat", if1.cnt_x, 8'd133);
        pulse_snap();
        check8("snap1 x_pos",      if0.x_pos,  8'd133);
        check8("snap1 status",     if0.status, 8'h41);
        check8("snap1 status sat", if1.status, 8'h41);
        check8("snap1 y_pos",      if0.y_pos,  8'd128);
        pulse_snap();
        check8("snap2 status",     if0.status, 8'h80);
        check8("snap2 x_pos",      if0.x_pos,  8'd133);

        // Y up to 254, then three more: wrap versus clamp.
        for (int i = 0; i < 126; i++) drive_y(fwd(yph));
        check8("y254 cnt_y",     if0.cnt_y, 8'd254);
        check8("y254 cnt_y sat", if1.cnt_y, 8'd254);
        pulse_snap();
        check8("snap3 status",   if0.status, 8'hC2);
        for (int i = 0; i < 3; i++) drive_y(fwd(yph));
        check8("wrap cnt_y",      if0.cnt_y, 8'd1);
        check8("clamp cnt_y sat", if1.cnt_y, 8'd255);
        pulse_snap();
        check8("snap4 y_pos",      if0.y_pos,  8'd1);
        check8("snap4 y_pos sat",  if1.y_pos,  8'd255);
        check8("snap4 status",     if0.status, 8'h22);
        check8("snap4 status sat", if1.status, 8'h22);

        // Zero, then 200 steps backwards on X.
        pulse_zero();
        check8("zero cnt_x",     if0.cnt_x, 8'd128);
        check8("zero cnt_y",     if0.cnt_y, 8'd128);
        check8("zero cnt_x sat", if1.cnt_x, 8'd128);
        for (int i = 0; i < 200; i++) drive_x(bwd(xph));
        check8("back cnt_x",     if0.cnt_x, 8'd184);
        check8("back cnt_x sat", if1.cnt_x, 8'd0);
        pulse_snap();
        check8("snap5 status",     if0.status, 8'h51);
        check8("snap5 status sat", if1.status, 8'h51);
        check8("snap5 x_pos sat",  if1.x_pos,  8'd0);

        // Illegal jump: both channels change at once (01 -> 10).
        drive_x(2'b10);
        check8("err cnt_x",     if0.cnt_x, 8'd184);
        check8("err cnt_x sat", if1.cnt_x, 8'd0);
        pulse_snap();
        check8("snap6 status",     if0.status, 8'h84);
        check8("snap6 status sat", if1.status, 8'h84);

        // A Y step lands on the same edge as snap.
        @(negedge clk);
        yph = fwd(yph);
        if0.y_a = yph[1];
        if0.y_b = yph[0];
        @(negedge clk);
        @(negedge clk);
        if0.snap = 1'b1;
        @(negedge clk);
        if0.snap = 1'b0;
        check8("coinc y_pos",  if0.y_pos,  8'd128);
        check8("coinc status", if0.status, 8'hC0);
        check8("coinc cnt_y",  if0.cnt_y,  8'd129);
        repeat (2) @(negedge clk);
        pulse_snap();
        check8("snap8 status", if0.status, 8'h02);
        check8("snap8 y_pos",  if0.y_pos,  8'd129);

        // Asynchronous reset in the middle of a step.
        @(negedge clk);
        xph = fwd(xph);
        if0.x_a = xph[1];
        if0.x_b = xph[0];
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check8("mid rst cnt_x",      if0.cnt_x,  8'd128);
        check8("mid rst cnt_y",      if0.cnt_y,  8'd128);
        check8("mid rst x_pos",      if0.x_pos,  8'd128);
        check8("mid rst y_pos",      if0.y_pos,  8'd128);
        check8("mid rst status",     if0.status, 8'h00);
        check8("mid rst x_pos sat",  if1.x_pos,  8'd128);
        check8("mid rst status sat", if1.status, 8'h00);

        if0.x_a = 1'b0; if0.x_b = 1'b0;
        if0.y_a = 1'b0; if0.y_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check8("post rst cnt_x", if0.cnt_x, 8'd128);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
